// File: rtl/lo_sle_spi_shifter_if.sv
// ---------------------------------------------------------------------------
// lo_sle_spi_shifter_if
// Groups the LO_SLE control word and the synthesizer 3-wire pins into one
// bundle. The "master" side owns the control word (software register side),
// the "slave" side is the shifter that drives the synthesizer pins.
// Optional readback signals exist only when LO_SLE_READBACK_EN is defined.
// ---------------------------------------------------------------------------
interface lo_sle_spi_shifter_if #(
    parameter int DATA_W = 24
);
    logic [31:0]       cfg_word;
    logic              spi_clk;
    logic              spi_data;
    logic              spi_le;
    logic              busy;
    logic [15:0]       xfer_cnt;
`ifdef LO_SLE_READBACK_EN
    logic              spi_miso;
    logic [DATA_W-1:0] rdbk_data;

    modport master (
        output cfg_word,
        output spi_miso,
        input  spi_clk,
        input  spi_data,
        input  spi_le,
        input  busy,
        input  xfer_cnt,
        input  rdbk_data
    );

    modport slave (
        input  cfg_word,
        input  spi_miso,
        output spi_clk,
        output spi_data,
        output spi_le,
        output busy,
        output xfer_cnt,
        output rdbk_data
    );
`else
    modport master (
        output cfg_word,
        input  spi_clk,
        input  spi_data,
        input  spi_le,
        input  busy,
        input  xfer_cnt
    );

    modport slave (
        input  cfg_word,
        output spi_clk,
        output spi_data,
        output spi_le,
        output busy,
        output xfer_cnt
    );
`endif
endinterface

// File: rtl/lo_sle_spi_shifter.sv
// ---------------------------------------------------------------------------
// lo_sle_spi_shifter
// Serialises the payload of the software-written LO_SLE control word onto the
// LO synthesizer 3-wire port (spi_clk / spi_data / spi_le). A transfer is
// requested by toggling cfg_word[31]; there is no write strobe.
//
// Sequence: IDLE -> SHIFT (DATA_W bits, MSB first, CLK_DIV cycles per bit,
// clock low for the first half of each bit) -> GAP (HALF cycles, clock low,
// data held) -> LATCH (spi_le high for LE_CYCLES) -> IDLE.
//
// Optional feature macro: LO_SLE_READBACK_EN
//   When defined, spi_miso is sampled on every spi_clk rising cycle during
//   SHIFT and the captured word is published on rdbk_data at LATCH entry.
//   When undefined, the readback ports and logic are absent.
//
// All pin-facing outputs come straight from flops.
// ---------------------------------------------------------------------------
module lo_sle_spi_shifter #(
    parameter int DATA_W    = 24,
    parameter int CLK_DIV   = 4,
    parameter int LE_CYCLES = 2
) (
    input  logic                 user_clk,
    input  logic                 user_rst_n,
    lo_sle_spi_shifter_if.slave  bus
);

    // Half a serial clock period, in user_clk cycles.
    localparam int HALF = CLK_DIV / 2;
    // One shared timer covers both the half-period and the latch pulse width.
    localparam int TMAX = (HALF > LE_CYCLES) ? HALF : LE_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int BW   = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2,
        ST_LATCH = 2'd3
    } state_t;

    // Registered copy of the control word (only the bits that matter).
    logic              r_cfg_tog;
    logic [DATA_W-1:0] r_cfg_pl;

    // Sequencer state.
    state_t            r_state;
    logic              r_last_tog;
    logic [DATA_W-1:0] r_shift;
    logic [TW-1:0]     r_tmr;
    logic [BW-1:0]     r_bit;

    // Output flops.
    logic              r_spi_clk;
    logic              r_spi_data;
    logic              r_spi_le;
    logic              r_busy;
    logic [15:0]       r_xfer_cnt;

    // Combinational helpers.
    logic              w_req;
    logic              w_half_done;
    logic              w_le_done;
    logic              w_last_bit;
    logic [DATA_W-1:0] w_shift_next;

    assign w_req        = (r_cfg_tog != r_last_tog);
    assign w_half_done  = (r_tmr == TW'(HALF - 1));
    assign w_le_done    = (r_tmr == TW'(LE_CYCLES - 1));
    assign w_last_bit   = (r_bit == BW'(DATA_W - 1));
    assign w_shift_next = r_shift << 1'b1;

    // Bits of the control word between the payload and the toggle are ignored.
    generate
        if (DATA_W < 31) begin : g_cfg_unused
            logic w_unused_cfg;
            assign w_unused_cfg = ^bus.cfg_word[30:DATA_W];
        end
    endgenerate

    // Capture the control word once so every decision sees a single stable copy.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            r_cfg_tog <= 1'b0;
            r_cfg_pl  <= {DATA_W{1'b0}};
        end else begin
            r_cfg_tog <= bus.cfg_word[31];
            r_cfg_pl  <= bus.cfg_word[DATA_W-1:0];
        end
    end

    // Transfer sequencer: owns the state, the shift register and every pin flop.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            r_state    <= ST_IDLE;
            r_last_tog <= 1'b0;
            r_shift    <= {DATA_W{1'b0}};
            r_tmr      <= {TW{1'b0}};
            r_bit      <= {BW{1'b0}};
            r_spi_clk  <= 1'b0;
            r_spi_data <= 1'b0;
            r_spi_le   <= 1'b0;
            r_busy     <= 1'b0;
            r_xfer_cnt <= 16'h0000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_spi_clk <= 1'b0;
                    r_spi_le  <= 1'b0;
                    if (w_req) begin
                        // Payload is frozen here; later cfg_word edits wait
                        // for the next visit to IDLE.
                        r_shift    <= r_cfg_pl;
                        r_spi_data <= r_cfg_pl[DATA_W-1];
                        r_last_tog <= r_cfg_tog;
                        r_busy     <= 1'b1;
                        r_tmr      <= {TW{1'b0}};
                        r_bit      <= {BW{1'b0}};
                        r_state    <= ST_SHIFT;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end

                ST_SHIFT: begin
                    if (w_half_done) begin
                        r_tmr <= {TW{1'b0}};
                        if (!r_spi_clk) begin
                            // Second half of the bit: clock high.
                            r_spi_clk <= 1'b1;
                        end else begin
                            // End of bit: clock back low, then next bit or GAP.
                            r_spi_clk <= 1'b0;
                            if (w_last_bit) begin
                                r_state <= ST_GAP;
                            end else begin
                                r_bit      <= r_bit + BW'(1);
                                r_shift    <= w_shift_next;
                                r_spi_data <= w_shift_next[DATA_W-1];
                            end
                        end
                    end else begin
                        r_tmr <= r_tmr + TW'(1);
                    end
                end

                ST_GAP: begin
                    // Clock stays low and data holds the last bit.
                    r_spi_clk <= 1'b0;
                    if (w_half_done) begin
                        r_tmr    <= {TW{1'b0}};
                        r_spi_le <= 1'b1;
                        r_state  <= ST_LATCH;
                    end else begin
                        r_tmr <= r_tmr + TW'(1);
                    end
                end

                ST_LATCH: begin
                    r_spi_clk <= 1'b0;
                    if (w_le_done) begin
                        // Pulse end, busy drop and count bump share one edge.
                        r_tmr      <= {TW{1'b0}};
                        r_spi_le   <= 1'b0;
                        r_spi_data <= 1'b0;
                        r_busy     <= 1'b0;
                        r_xfer_cnt <= r_xfer_cnt + 16'h0001;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_tmr <= r_tmr + TW'(1);
                    end
                end

                default: begin
                    // Unreachable encoding: park safely with the pins quiet.
                    r_state    <= ST_IDLE;
                    r_tmr      <= {TW{1'b0}};
                    r_spi_clk  <= 1'b0;
                    r_spi_data <= 1'b0;
                    r_spi_le   <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

`ifdef LO_SLE_READBACK_EN
    logic              w_rise;
    logic              w_latch_entry;
    logic              w_start;
    logic [DATA_W-1:0] r_rd_shift;
    logic [DATA_W-1:0] r_rdbk;
    logic [DATA_W-1:0] w_rd_next;

    // spi_clk is about to go high in this cycle: that is the sampling point.
    assign w_rise        = (r_state == ST_SHIFT) && w_half_done && !r_spi_clk;
    assign w_latch_entry = (r_state == ST_GAP) && w_half_done;
    assign w_start       = (r_state == ST_IDLE) && w_req;

    generate
        if (DATA_W == 1) begin : g_rd_one
            assign w_rd_next = bus.spi_miso;
        end else begin : g_rd_many
            assign w_rd_next = {r_rd_shift[DATA_W-2:0], bus.spi_miso};
        end
    endgenerate

    // Collect readback bits MSB first; start each transfer from a clean word.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            r_rd_shift <= {DATA_W{1'b0}};
        end else if (w_start) begin
            r_rd_shift <= {DATA_W{1'b0}};
        end else if (w_rise) begin
            r_rd_shift <= w_rd_next;
        end else begin
            r_rd_shift <= r_rd_shift;
        end
    end

    // Publish the readback word once, on the cycle LATCH is entered.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            r_rdbk <= {DATA_W{1'b0}};
        end else if (w_latch_entry) begin
            r_rdbk <= r_rd_shift;
        end else begin
            r_rdbk <= r_rdbk;
        end
    end

    assign bus.rdbk_data = r_rdbk;
`endif

    assign bus.spi_clk  = r_spi_clk;
    assign bus.spi_data = r_spi_data;
    assign bus.spi_le   = r_spi_le;
    assign bus.busy     = r_busy;
    assign bus.xfer_cnt = r_xfer_cnt;

endmodule

// File: tb/tb_lo_sle_spi_shifter.sv
// ---------------------------------------------------------------------------
// tb_lo_sle_spi_shifter
// Scoreboard bench: stimulus pushes one expected transfer per request into a
// queue; a monitor watches the pins, reassembles each transfer and pops/compares
// when busy falls. Covers reset state, release-with-request, directed payloads,
// odd/even toggles during busy, reset mid-transfer and counter wrap, plus a
// randomized loop. Readback is checked when LO_SLE_READBACK_EN is defined.
// ---------------------------------------------------------------------------
module tb_lo_sle_spi_shifter;

    localparam int DATA_W    = 24;
    localparam int CLK_DIV   = 4;
    localparam int LE_CYCLES = 2;
    localparam int HALF      = CLK_DIV / 2;
    localparam int BUSY_LEN  = DATA_W * CLK_DIV + HALF + LE_CYCLES;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lo_sle_spi_shifter_if #(.DATA_W(DATA_W)) bus ();

    lo_sle_spi_shifter #(
        .DATA_W   (DATA_W),
        .CLK_DIV  (CLK_DIV),
        .LE_CYCLES(LE_CYCLES)
    ) dut (
        .user_clk  (clk),
        .user_rst_n(rst_n),
        .bus       (bus.slave)
    );

    typedef struct {
        logic [DATA_W-1:0] pl;
        logic [15:0]       cnt;
        int                start;   // absolute cycle, or -1 = one cycle after previous end
    } exp_t;

    exp_t              sb_q[$];
    logic [15:0]       model_cnt = 16'h0000;
    logic [DATA_W-1:0] cur_pl;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [DATA_W-1:0] pl, input int start);
        exp_t e;
        model_cnt = model_cnt + 16'h0001;
        e.pl    = pl;
        e.cnt   = model_cnt;
        e.start = start;
        sb_q.push_back(e);
    endtask

    task automatic set_cfg(input logic tog, input logic [DATA_W-1:0] pl);
        logic [6:0] junk;
        junk = 7'($urandom);
        bus.cfg_word = {tog, junk, pl};
        cur_pl = pl;
    endtask

    // Toggle bit 31 right after a clock edge; the DUT should go busy two edges later.
    task automatic request(input logic [DATA_W-1:0] pl);
        @(posedge clk);
        #1;
        set_cfg(~bus.cfg_word[31], pl);
        push_exp(pl, cyc + 2);
    endtask

    task automatic wait_done(input int budget);
        int n;
        int quiet;
        n = 0;
        quiet = 0;
        while (quiet < 3 && n < budget) begin
            @(negedge clk);
            n++;
            if (!bus.busy && sb_q.size() == 0) quiet++;
            else quiet = 0;
        end
        chk("wait_done_timeout", (quiet >= 3) ? 32'd1 : 32'd0, 32'd1);
    endtask

    // ---------------- monitor ----------------
    logic              prev_busy = 1'b0;
    logic              prev_clk  = 1'b0;
    logic              prev_le   = 1'b0;
    int                start_cyc = 0;
    int                last_end  = -100;
    logic [DATA_W-1:0] bits;
    int                nbits, busy_len, le_len, gap_len;
`ifdef LO_SLE_READBACK_EN
    logic [DATA_W-1:0] rb_pat;
    int                rb_idx = 0;
    int                rb_n   = 0;
`endif

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_busy = 1'b0;
            prev_clk  = 1'b0;
            prev_le   = 1'b0;
            nbits     = 0;
            le_len    = 0;
        end else begin
            if (bus.busy && !prev_busy) begin
                start_cyc = cyc;
                bits = '0;
                nbits = 0; busy_len = 0; le_len = 0; gap_len = 0;
`ifdef LO_SLE_READBACK_EN
                rb_pat = (rb_n % 2 == 0) ? 24'h5A5A5A : 24'($urandom);
                rb_n++;
                rb_idx = DATA_W - 1;
                bus.spi_miso = rb_pat[rb_idx];
`endif
            end
            if (bus.busy) busy_len++;
            if (bus.spi_clk && !prev_clk) begin
                bits = {bits[DATA_W-2:0], bus.spi_data};
                nbits++;
            end
            if (bus.busy && nbits == DATA_W && !bus.spi_clk && !bus.spi_le && le_len == 0)
                gap_len++;
            if (bus.spi_le) le_len++;
`ifdef LO_SLE_READBACK_EN
            if (bus.spi_le && !prev_le) chk("rdbk_data", 32'(bus.rdbk_data), 32'(rb_pat));
            if (!bus.spi_clk && prev_clk && rb_idx > 0) begin
                rb_idx--;
                bus.spi_miso = rb_pat[rb_idx];
            end
`endif
            if (!bus.busy && prev_busy) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_xfer actual=%0h expected=none (cycle %0d)", bits, cyc);
                end else begin
                    e = sb_q.pop_front();
                    chk("payload",  32'(bits), 32'(e.pl));
                    chk("nbits",    nbits, DATA_W);
                    chk("busy_len", busy_len, BUSY_LEN);
                    chk("le_len",   le_len, LE_CYCLES);
                    chk("gap_len",  gap_len, HALF);
                    chk("xfer_cnt", 32'(bus.xfer_cnt), 32'(e.cnt));
                    chk("start",    start_cyc, (e.start >= 0) ? e.start : last_end + 1);
                    chk("le_low_at_end", 32'(bus.spi_le), 32'd0);
                end
                last_end = cyc;
            end
            prev_busy = bus.busy;
            prev_clk  = bus.spi_clk;
            prev_le   = bus.spi_le;
        end
    end

    // Hard stop in case something deadlocks outside the bounded waits.
    initial begin
        #2000000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int saw;
        logic [DATA_W-1:0] pl;

        bus.cfg_word = 32'h80FFFFFF;
`ifdef LO_SLE_READBACK_EN
        bus.spi_miso = 1'b0;
`endif
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_spi_clk",  32'(bus.spi_clk),  32'd0);
        chk("rst_spi_data", 32'(bus.spi_data), 32'd0);
        chk("rst_spi_le",   32'(bus.spi_le),   32'd0);
        chk("rst_busy",     32'(bus.busy),     32'd0);
        chk("rst_xfer_cnt", 32'(bus.xfer_cnt), 32'd0);
`ifdef LO_SLE_READBACK_EN
        chk("rst_rdbk", 32'(bus.rdbk_data), 32'd0);
`endif
        // Release with bit 31 already set: a transfer starts by itself.
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cur_pl = 24'hFFFFFF;
        push_exp(24'hFFFFFF, cyc + 2);
        wait_done(400);

        // Directed payloads.
        request(24'h000000);
        wait_done(400);
        request(24'hA5C3F0);
        wait_done(400);

        // One toggle during busy -> one follow-up with the new payload.
        request(24'($urandom));
        repeat (20) @(posedge clk);
        #1;
        set_cfg(~bus.cfg_word[31], 24'h123456);
        push_exp(24'h123456, -1);
        wait_done(600);

        // Two toggles during busy -> no follow-up.
        request(24'($urandom));
        repeat (15) @(posedge clk);
        #1;
        set_cfg(~bus.cfg_word[31], 24'($urandom));
        repeat (15) @(posedge clk);
        #1;
        set_cfg(~bus.cfg_word[31], 24'($urandom));
        wait_done(600);
        saw = 0;
        repeat (120) begin
            @(negedge clk);
            if (bus.busy) saw = 1;
        end
        chk("no_followup_even", saw, 0);
        chk("xfer_cnt_even", 32'(bus.xfer_cnt), 32'(model_cnt));

        // Reset in the middle of bit 10.
        request(24'($urandom));
        repeat (43) @(posedge clk);
        #2;
        rst_n = 1'b0;
        sb_q.delete();
        model_cnt = 16'h0000;
        #1;
        chk("mid_rst_spi_clk",  32'(bus.spi_clk),  32'd0);
        chk("mid_rst_spi_data", 32'(bus.spi_data), 32'd0);
        chk("mid_rst_spi_le",   32'(bus.spi_le),   32'd0);
        chk("mid_rst_busy",     32'(bus.busy),     32'd0);
        chk("mid_rst_xfer_cnt", 32'(bus.xfer_cnt), 32'd0);
        set_cfg(1'b1, 24'($urandom));
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_exp(cur_pl, cyc + 2);
        wait_done(400);

        // Counter wrap.
        @(negedge clk);
        force dut.r_xfer_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.r_xfer_cnt;
        model_cnt = 16'hFFFF;
        request(24'($urandom));
        wait_done(400);
        chk("xfer_cnt_wrap", 32'(bus.xfer_cnt), 32'd0);

        // Randomized requests with random in-flight toggles and payload edits.
        for (int it = 0; it < 10; it++) begin
            n = $urandom_range(0, 3);
            pl = 24'($urandom);
            request(pl);
            for (int k = 0; k < n; k++) begin
                repeat ($urandom_range(5, 18)) @(posedge clk);
                #1;
                set_cfg(~bus.cfg_word[31], 24'($urandom));
            end
            if ($urandom_range(0, 1) == 1) begin
                repeat (3) @(posedge clk);
                #1;
                set_cfg(bus.cfg_word[31], 24'($urandom));
            end
            if (n % 2 == 1) push_exp(cur_pl, -1);
            wait_done(800);
            repeat ($urandom_range(0, 4)) @(posedge clk);
        end

        saw = 0;
        repeat (150) begin
            @(negedge clk);
            if (bus.busy) saw = 1;
        end
        chk("final_quiet", saw, 0);
        chk("queue_empty", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
